// File: rtl/pc_stack_unit_if.sv
// Control/status bundle of the PC and return-stack unit.
// Master drives the control inputs, slave is the unit itself.
interface pc_stack_unit_if;
  logic [9:0] D_IN;
  logic       PC_LD;
  logic       PC_INC;
  logic       CALL;
  logic       RET;
  logic       INTR;
  logic       ERR_CLR;
  logic [9:0] PC_COUNT;
  logic [9:0] TOS;
  logic       FULL;
  logic       EMPTY;
  logic       OVF;
  logic       UNF;
  logic       INT_ACK;

  modport master (
    output D_IN, PC_LD, PC_INC, CALL,
    output RET, INTR, ERR_CLR,
    input  PC_COUNT, TOS, FULL, EMPTY,
    input  OVF, UNF, INT_ACK
  );

  modport slave (
    input  D_IN, PC_LD, PC_INC, CALL,
    input  RET, INTR, ERR_CLR,
    output PC_COUNT, TOS, FULL, EMPTY,
    output OVF, UNF, INT_ACK
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a DEPTH-entry return-address LIFO,
// interrupt entry and sticky overflow/underflow flags.
module pc_stack_unit #(
  parameter int         DEPTH    = 8,
  parameter logic [9:0] INTR_VEC = 10'h3FF
) (
  input  logic           CLK,
  input  logic           RST_N,
  pc_stack_unit_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [9:0]    stack [DEPTH];
  logic [CW-1:0] count;
  logic [9:0]    pc;
  logic          ovf;
  logic          unf;
  logic          int_ack;

  logic          full;
  logic          empty;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic [9:0]    pc_inc;

  logic act_intr;
  logic act_ld;
  logic act_call;
  logic act_ret;
  logic act_inc;

  logic       push;
  logic       pop;
  logic [9:0] push_val;
  logic [9:0] pc_next;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign top_idx = AW'(count - CW'(1));
  assign wr_idx  = AW'(count);
  assign pc_inc  = pc + 10'd1;

  // Resolve priority up front so the decode below is one-hot.
  assign act_intr = bus.INTR;
  assign act_ld   = bus.PC_LD  & ~bus.INTR;
  assign act_call = bus.CALL   & ~bus.INTR & ~bus.PC_LD;
  assign act_ret  = bus.RET    & ~bus.INTR & ~bus.PC_LD
                  & ~bus.CALL;
  assign act_inc  = bus.PC_INC & ~bus.INTR & ~bus.PC_LD
                  & ~bus.CALL  & ~bus.RET;

  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    push_val = pc;
    pc_next  = pc;
    unique case (1'b1)
      act_intr: begin
        push     = 1'b1;
        push_val = pc;
        pc_next  = INTR_VEC;
      end
      act_ld: pc_next = bus.D_IN;
      act_call: begin
        push     = 1'b1;
        push_val = pc_inc;
        pc_next  = bus.D_IN;
      end
      act_ret: begin
        pop = 1'b1;
        if (!empty) pc_next = stack[top_idx];
      end
      act_inc: pc_next = pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc      <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      int_ack <= 1'b0;
    end else begin
      pc      <= pc_next;
      int_ack <= act_intr;
      ovf     <= (ovf & ~bus.ERR_CLR) | (push & full);
      unf     <= (unf & ~bus.ERR_CLR) | (pop & empty);
      if (push && !full)
        count <= count + CW'(1);
      else if (pop && !empty)
        count <= count - CW'(1);
    end
  end

  // Entries need no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (RST_N && push && !full)
      stack[wr_idx] <= push_val;
  end

  assign bus.PC_COUNT = pc;
  assign bus.TOS      = empty ? 10'd0 : stack[top_idx];
  assign bus.FULL     = full;
  assign bus.EMPTY    = empty;
  assign bus.OVF      = ovf;
  assign bus.UNF      = unf;
  assign bus.INT_ACK  = int_ack;

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of return-stack entries (power of two, 2..16).
REQ-002 The block SHALL have parameter INTR_VEC, default 10'h3FF, meaning the interrupt vector address.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port D_IN, input, 10 bits: the jump/call target from the upstream 2-input PC source mux.
REQ-006 The block SHALL have port PC_LD, input, 1 bit: load D_IN into the PC.
REQ-007 The block SHALL have port PC_INC, input, 1 bit: increment the PC.
REQ-008 The block SHALL have port CALL, input, 1 bit: push the return address and jump to D_IN.
REQ-009 The block SHALL have port RET, input, 1 bit: pop the stack into the PC.
REQ-010 The block SHALL have port INTR, input, 1 bit: interrupt request, level-sampled.
REQ-011 The block SHALL have port ERR_CLR, input, 1 bit: clear the sticky error flags.
REQ-012 The block SHALL have port PC_COUNT, output, 10 bits: the current program counter.
REQ-013 The block SHALL have port TOS, output, 10 bits: the top-of-stack value.
REQ-014 The block SHALL have port FULL, output, 1 bit: the stack holds DEPTH entries.
REQ-015 The block SHALL have port EMPTY, output, 1 bit: the stack holds 0 entries.
REQ-016 The block SHALL have port OVF, output, 1 bit: sticky flag, push attempted while full.
REQ-017 The block SHALL have port UNF, output, 1 bit: sticky flag, pop attempted while empty.
REQ-018 The block SHALL have port INT_ACK, output, 1 bit: one-cycle pulse, interrupt taken.

Function
REQ-019 The block SHALL hold a 10-bit PC register and a DEPTH x 10-bit LIFO with an occupancy count in the range 0..DEPTH.
REQ-020 Per rising edge, exactly one action SHALL be performed, in this priority order: INTR > PC_LD > CALL > RET > PC_INC > hold.
REQ-021 On INTR, the block SHALL push the current PC, set PC = INTR_VEC, and assert INT_ACK for exactly the following cycle.
REQ-022 On PC_LD, the block SHALL set PC = D_IN and leave the stack unchanged.
REQ-023 On CALL, the block SHALL push (PC+1) mod 1024 and set PC = D_IN.
REQ-024 On RET, the block SHALL pop the top entry into PC.
REQ-025 On PC_INC, the block SHALL set PC = (PC+1) mod 1024, so that 0x3FF wraps to 0x000.
REQ-026 Every action SHALL have a latency of 1 cycle: the new PC_COUNT is visible after the active edge.
REQ-027 A push while FULL SHALL leave the stack contents and count unchanged, still update the PC, and set OVF.
REQ-028 A pop while EMPTY SHALL leave the PC and count unchanged and set UNF.
REQ-029 OVF and UNF SHALL stay set until ERR_CLR or reset; if ERR_CLR and a new error occur in the same cycle, the flag SHALL end set.
REQ-030 TOS SHALL be combinational from the top entry and SHALL read 0 when EMPTY.
REQ-031 FULL and EMPTY SHALL be combinational decodes of the occupancy count.
REQ-032 PC_COUNT, OVF, UNF and INT_ACK SHALL be registered.
REQ-033 A push followed by a pop SHALL return the pushed value; nesting SHALL be strict LIFO up to DEPTH levels.

Reset
REQ-034 While RST_N = 0, the block SHALL immediately force, independent of CLK: PC_COUNT = 0, count = 0, OVF = 0, UNF = 0, INT_ACK = 0; consequently EMPTY = 1, FULL = 0 and TOS = 0.
REQ-035 Reset asserted mid-operation SHALL abandon any pending action, and no stack entry SHALL be recoverable afterwards.
REQ-036 The first state update SHALL occur on the first rising CLK edge after RST_N returns to 1.

Verification
REQ-037 The bench SHALL drive reset then PC_INC for 3 cycles -> PC_COUNT = 0x001, 0x002, 0x003; then PC_LD with D_IN = 0x3FF, then PC_INC -> PC_COUNT = 0x3FF, then 0x000.
REQ-038 The bench SHALL drive PC = 0x010, CALL with D_IN = 0x100, then RET -> PC_COUNT = 0x100 with TOS = 0x011, then PC_COUNT = 0x011 with EMPTY = 1.
REQ-039 The bench SHALL drive DEPTH+1 consecutive CALLs -> FULL = 1 after DEPTH calls, OVF = 1 after the extra call, and DEPTH RETs return the first DEPTH return addresses in reverse order.
REQ-040 The bench SHALL drive RET while EMPTY with PC = 0x055 -> PC_COUNT stays 0x055 and UNF = 1; then ERR_CLR -> UNF = 0.
REQ-041 The bench SHALL assert INTR, PC_LD and CALL in the same cycle with PC = 0x020 -> PC_COUNT = 0x3FF, TOS = 0x020, and INT_ACK high for exactly one cycle.
REQ-042 The bench SHALL pull RST_N low between clock edges after 3 pushes -> all outputs take their reset values before the next CLK edge, and EMPTY = 1.
